// File: rtl/countdown_timer_arbiter.sv
// Shares one WIDTH-bit down-counter among N_REQ requesters (round-robin grant, load, count to zero, done pulse).
// Define CDT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, pointer held at reset value).
module countdown_timer_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] req_val_i,
  input  logic                   abort_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [ID_W-1:0]        gnt_id_o,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       cnt_o,
  output logic [N_REQ-1:0]       done_o
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic [WIDTH-1:0] val_arr [N_REQ];
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;

  always_comb begin : unpack_vals
    for (int unsigned i = 0; i < N_REQ; i++) begin
      val_arr[i] = req_val_i[i*WIDTH +: WIDTH];
    end
  end

  // Winner selection; the first hit in search order wins.
  always_comb begin : arbitrate
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
`ifdef CDT_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_W'(i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
`else
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
`endif
  end

  always_comb begin : next_state
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    ptr_d    = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_COUNT;
          gnt_d    = N_REQ'(1) << win_id;
          gnt_id_d = win_id;
          cnt_d    = val_arr[win_id];
          busy_d   = 1'b1;
        end
      end
      S_COUNT: begin
        // Abort takes precedence over reaching zero: no done pulse.
        if (abort_i) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '1;
`ifndef CDT_ARB_FIXED_PRIO_EN
          ptr_d   = gnt_id_q;
`endif
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '1;
`ifndef CDT_ARB_FIXED_PRIO_EN
        ptr_d   = gnt_id_q;
`endif
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= ID_W'(N_REQ - 1);
      busy_q   <= 1'b0;
      cnt_q    <= '1;
      done_q   <= '0;
      ptr_q    <= ID_W'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = gnt_id_q;
  assign busy_o   = busy_q;
  assign cnt_o    = cnt_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_countdown_timer_arbiter.sv
// Table-driven bench for countdown_timer_arbiter: per-cycle vectors with a scoreboard queue,
// plus a hand-written asynchronous-reset sequence.
module tb_countdown_timer_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_val;
  logic        abort;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [3:0]  cnt;
  logic [3:0]  done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] val;
    logic        abort;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        busy;
    logic [3:0]  cnt;
    logic [3:0]  done;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  countdown_timer_arbiter #(.WIDTH(4), .N_REQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .req_val_i (req_val),
    .abort_i   (abort),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .busy_o    (busy),
    .cnt_o     (cnt),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [15:0] v,
                              input logic ab, input logic [3:0] g, input logic [1:0] id,
                              input logic b, input logic [3:0] c, input logic [3:0] d);
    vec_t t;
    t.rst = rst; t.req = rq; t.val = v; t.abort = ab;
    t.gnt = g; t.id = id; t.busy = b; t.cnt = c; t.done = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".gnt"},    32'(gnt),    32'h0);
    chk({tag, ".done"},   32'(done),   32'h0);
    chk({tag, ".busy"},   32'(busy),   32'h0);
    chk({tag, ".gnt_id"}, 32'(gnt_id), 32'h3);
    chk({tag, ".cnt"},    32'(cnt),    32'hF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; abort = 1'b0;
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int n);
    vec_t e;
    string tag;
    if (v.rst) do_reset();
    @(negedge clk);
    req = v.req; req_val = v.val; abort = v.abort;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tag = $sformatf("v%0d", n);
    chk({tag, ".gnt"},    32'(gnt),    32'(e.gnt));
    chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(e.id));
    chk({tag, ".busy"},   32'(busy),   32'(e.busy));
    chk({tag, ".cnt"},    32'(cnt),    32'(e.cnt));
    chk({tag, ".done"},   32'(done),   32'(e.done));
  endtask

  initial begin
    reset = 1'b1; req = '0; req_val = '0; abort = 1'b0;
    #12;
    reset = 1'b0;

`ifdef CDT_ARB_FIXED_PRIO_EN
    // req=0110 held: requester 1 wins every time
    tbl.push_back(mk(1, 4'b0110, 16'h0000, 0, 4'b0010, 2'd1, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b0110, 16'h0000, 0, 4'b0010, 2'd1, 1, 4'h0, 4'b0010));
    tbl.push_back(mk(0, 4'b0110, 16'h0000, 0, 4'b0000, 2'd1, 0, 4'hF, 4'b0000));
    tbl.push_back(mk(0, 4'b0110, 16'h0000, 0, 4'b0010, 2'd1, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b0110, 16'h0000, 0, 4'b0010, 2'd1, 1, 4'h0, 4'b0010));
    tbl.push_back(mk(0, 4'b0110, 16'h0000, 0, 4'b0000, 2'd1, 0, 4'hF, 4'b0000));
    tbl.push_back(mk(0, 4'b0110, 16'h0000, 0, 4'b0010, 2'd1, 1, 4'h0, 4'b0000));
`else
    // single request, value 3; req dropped after grant
    tbl.push_back(mk(1, 4'b0001, 16'h0003, 0, 4'b0001, 2'd0, 1, 4'h3, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0003, 0, 4'b0001, 2'd0, 1, 4'h2, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0003, 0, 4'b0001, 2'd0, 1, 4'h1, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0000, 2'd0, 0, 4'hF, 4'b0000));
    // all requesting with zero values: round robin 0,1,2,3,0
    tbl.push_back(mk(1, 4'b1111, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0001));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0000, 2'd0, 0, 4'hF, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0010, 2'd1, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0010, 2'd1, 1, 4'h0, 4'b0010));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0000, 2'd1, 0, 4'hF, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0100, 2'd2, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0100, 2'd2, 1, 4'h0, 4'b0100));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0000, 2'd2, 0, 4'hF, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b1000, 2'd3, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b1000, 2'd3, 1, 4'h0, 4'b1000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0000, 2'd3, 0, 4'hF, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0000, 2'd0, 0, 4'hF, 4'b0000));
    // requester 2 value 9, value changed mid-count, abort at cnt==5
    tbl.push_back(mk(0, 4'b0100, 16'h0900, 0, 4'b0100, 2'd2, 1, 4'h9, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0100, 0, 4'b0100, 2'd2, 1, 4'h8, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0100, 2'd2, 1, 4'h7, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0100, 2'd2, 1, 4'h6, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0100, 2'd2, 1, 4'h5, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 2'd2, 0, 4'hF, 4'b0000));
    // search resumes at 3 after the abort
    tbl.push_back(mk(0, 4'b1011, 16'h2000, 0, 4'b1000, 2'd3, 1, 4'h2, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b1000, 2'd3, 1, 4'h1, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b1000, 2'd3, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b1000, 2'd3, 1, 4'h0, 4'b1000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0000, 2'd3, 0, 4'hF, 4'b0000));
    // abort with cnt==0 wins; abort ignored in IDLE and DONE
    tbl.push_back(mk(0, 4'b0010, 16'h0010, 0, 4'b0010, 2'd1, 1, 4'h1, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0010, 2'd1, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 2'd1, 0, 4'hF, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 16'h0000, 1, 4'b0001, 2'd0, 1, 4'h0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 2'd0, 0, 4'hF, 4'b0000));
    // count requester 2 from 8 down to 6 before the async reset below
    tbl.push_back(mk(0, 4'b0100, 16'h0800, 0, 4'b0100, 2'd2, 1, 4'h8, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0100, 2'd2, 1, 4'h7, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0100, 2'd2, 1, 4'h6, 4'b0000));
`endif

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

`ifndef CDT_ARB_FIXED_PRIO_EN
    // Asynchronous reset mid-count: outputs drop between clock edges
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0, 4'b1111, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0000), 900);
    apply(mk(0, 4'b0000, 16'h0000, 0, 4'b0001, 2'd0, 1, 4'h0, 4'b0001), 901);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer_arbiter.md
# countdown_timer_arbiter

Shares a single WIDTH-bit down-counting timer among N_REQ requesters. Each requester presents a count value. The arbiter grants the timer to one requester at a time, loads the value, and counts down to zero. It then pulses that requester's done line and returns to idle. The block sits between the timer users (protocol timeouts, delay generators) and the down-counter datapath, and is the only agent that loads or clocks the timer.

## Interface
- WIDTH, 4, timer/count width in bits
- N_REQ, 4, number of requesters (2..8)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level; bit i belongs to requester i
- req_val  in  N_REQ*WIDTH  count values; requester i uses bits [i*WIDTH +: WIDTH]
- abort  in  1  terminates the active countdown
- gnt  out  N_REQ  one-hot grant, zero when idle
- gnt_id  out  $clog2(N_REQ)  index of the current/last grant
- busy  out  1  high in COUNT and DONE
- cnt  out  WIDTH  current timer value
- done  out  N_REQ  one-cycle completion pulse to the granted requester

## Operation
- Every output is registered. Reset values:
  - gnt=0, done=0, busy=0, gnt_id=N_REQ-1, cnt=all ones
  - state=IDLE, round-robin pointer=N_REQ-1
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If no req bit is set, hold; cnt stays all ones.
  - Otherwise select the winner i and move to COUNT: gnt[i]=1, gnt_id=i, cnt=req_val[i], busy=1.
- COUNT:
  - If abort: go to IDLE. gnt=0, busy=0, cnt=all ones, no done pulse.
  - Else if cnt==0: go to DONE. done[i]=1, gnt held.
  - Else: cnt=cnt-1 (unsigned, no wrap possible).
- DONE:
  - Always go to IDLE: done=0, gnt=0, busy=0, cnt=all ones.
  - The pointer updates to i.
- Abort is ignored in IDLE and DONE.
- The pointer also updates to i on abort.
- Round-robin arbitration: search order starts at pointer+1 modulo N_REQ. After reset, requester 0 wins first.
- req and req_val are sampled only in IDLE. If the granted requester drops req or changes req_val mid-count, the countdown is unaffected.
- Simultaneous abort and cnt==0 in COUNT: abort wins, no done pulse.
- req_val=0: one COUNT cycle, then DONE.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous). No done pulse is generated.

## Timing
- Grant latency: one edge. A req seen high in IDLE at edge E0 gives gnt/busy/cnt=V valid after E0.
- cnt shows V, V-1, …, 0 on successive cycles after E0.
- done asserts after edge E0+V+1 and lasts exactly one cycle. gnt deasserts on the same edge that clears done (E0+V+2).
- Total grant duration: V+2 cycles.
- At least one IDLE cycle separates consecutive grants. The next grant appears after edge E0+V+3.

## Configuration
- CDT_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest requesting index always wins, and the pointer is unused (held at reset value).
- Not defined: round-robin as described in Operation.

## Test plan
- Reset then req=0001, req_val[0]=3:
  - gnt=0001 after first edge; cnt 3,2,1,0.
  - done[0] pulse in cycle 5 (counting from the grant cycle as cycle 1); gnt=0 in cycle 6.
- req=1111, all values 0, held high:
  - Grants occur in order 0,1,2,3,0.
  - Each grant is 2 cycles, separated by 1 idle cycle; one done pulse per grant.
- req[2]=1, req_val=9; abort pulsed when cnt==5:
  - Next cycle: IDLE, gnt=0, cnt=F, no done.
  - The next grant starts search at requester 3.
- abort asserted in the same cycle cnt==0: no done pulse; return to IDLE.
- Async reset asserted mid-count (cnt=6): gnt, busy, done drop with no clock edge; cnt=F. After release, requester 0 is granted first.
- With CDT_ARB_FIXED_PRIO_EN, req=0110 held: requester 1 granted every time; requester 2 is never granted.
